truth_table_sequencer: RTL and testbench

Self-test controller for the two-input basic logic gate block. On a start pulse it sweeps the gate block's A/B inputs through all four operand combinations and samples the eight gate outputs after a programmable settle time. It assembles a 4-bit truth table per gate, compares each against the expected table and reports a pass flag plus a per-gate failure mask. It sits between a test/CSR master and the gate datapath, which it drives exclusively while busy.

---
 rtl/truth_table_sequencer.sv | 119 +++++++++++
 tb/tb_truth_table_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: self-test controller for the two-input logic gate block.
// Sweeps {A,B} through 00,01,10,11, samples the eight gate outputs after a settle
// time, builds a 4-bit truth table per gate and compares it to the golden tables.
module truth_table_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        a_drv,
    output logic        b_drv,
    input  logic [7:0]  gate_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] tt_out,
    output logic [7:0]  fail_mask,
    output logic        pass
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);
    // Golden nibbles, gate 7 down to gate 0: xnor, xor, nand, nor, not_b, not_a, or, and
    localparam logic [31:0] EXPECTED = 32'h967153E8;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        CHECK,
        DONE
    } state_t;

    state_t        state;
    logic [1:0]    idx;
    logic [CW-1:0] cnt;
    logic [31:0]   sampled_tt;
    logic [7:0]    mismatch;

    // Truth table with the current gate outputs merged into column idx of every nibble
    always_comb begin
        sampled_tt = tt_out;
        for (int g = 0; g < 8; g++) begin
            sampled_tt[4*g + int'(idx)] = gate_in[g];
        end
    end

    // Per-gate comparison of the captured tables against the golden tables
    always_comb begin
        mismatch = '0;
        for (int g = 0; g < 8; g++) begin
            mismatch[g] = (tt_out[4*g +: 4] != EXPECTED[4*g +: 4]);
        end
    end

    // Sweep controller: state, operand drive, settle counter and registered results
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            a_drv     <= 1'b0;
            b_drv     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tt_out    <= '0;
            fail_mask <= '0;
            pass      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tt_out         <= '0;
                        fail_mask      <= '0;
                        pass           <= 1'b0;
                        idx            <= '0;
                        cnt            <= RELOAD;
                        {a_drv, b_drv} <= 2'b00;
                        busy           <= 1'b1;
                        state          <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                SAMPLE: begin
                    tt_out <= sampled_tt;
                    if (idx == 2'd3) begin
                        {a_drv, b_drv} <= 2'b00;
                        state          <= CHECK;
                    end else begin
                        idx            <= idx + 2'd1;
                        cnt            <= RELOAD;
                        {a_drv, b_drv} <= idx + 2'd1;
                        state          <= SETTLE;
                    end
                end
                CHECK: begin
                    fail_mask <= mismatch;
                    pass      <= ~|mismatch;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: drives three sequencers (settle 2, 1 and 5) against a
// behavioural gate block with injectable faults and checks cycle-by-cycle behaviour.
module tb_truth_table_sequencer;

    localparam int NI = 3;
    localparam int S0 = 2;
    localparam int S1 = 1;
    localparam int S2 = 5;
    localparam logic [31:0] GOLD = 32'h967153E8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] flt;

    logic        a_d    [NI];
    logic        b_d    [NI];
    logic        busy_d [NI];
    logic        done_d [NI];
    logic [31:0] tt_d   [NI];
    logic [7:0]  fm_d   [NI];
    logic        pass_d [NI];
    logic [7:0]  gin    [NI];

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_tt;
    logic [7:0]  exp_fm;
    logic        exp_pass;

    always #5 clk = ~clk;

    // Gate block model: real gate functions with selected truth-table entries inverted
    function automatic logic [7:0] gate_model(input logic a, input logic b, input logic [31:0] f);
        logic [1:0] i;
        logic [7:0] g;
        i    = {a, b};
        g[0] = a & b;
        g[1] = a | b;
        g[2] = ~a;
        g[3] = ~b;
        g[4] = ~(a | b);
        g[5] = ~(a & b);
        g[6] = a ^ b;
        g[7] = ~(a ^ b);
        for (int k = 0; k < 8; k++) begin
            g[k] = g[k] ^ f[4*k + int'(i)];
        end
        return g;
    endfunction

    assign gin[0] = gate_model(a_d[0], b_d[0], flt);
    assign gin[1] = gate_model(a_d[1], b_d[1], flt);
    assign gin[2] = gate_model(a_d[2], b_d[2], flt);

    truth_table_sequencer #(.SETTLE_CYCLES(S0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .a_drv(a_d[0]), .b_drv(b_d[0]),
        .gate_in(gin[0]), .busy(busy_d[0]), .done(done_d[0]), .tt_out(tt_d[0]),
        .fail_mask(fm_d[0]), .pass(pass_d[0])
    );

    truth_table_sequencer #(.SETTLE_CYCLES(S1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .a_drv(a_d[1]), .b_drv(b_d[1]),
        .gate_in(gin[1]), .busy(busy_d[1]), .done(done_d[1]), .tt_out(tt_d[1]),
        .fail_mask(fm_d[1]), .pass(pass_d[1])
    );

    truth_table_sequencer #(.SETTLE_CYCLES(S2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .a_drv(a_d[2]), .b_drv(b_d[2]),
        .gate_in(gin[2]), .busy(busy_d[2]), .done(done_d[2]), .tt_out(tt_d[2]),
        .fail_mask(fm_d[2]), .pass(pass_d[2])
    );

    function automatic int s_of(input int i);
        return (i == 0) ? S0 : (i == 1) ? S1 : S2;
    endfunction

    // Reference model: a gate fails exactly when any of its table entries was inverted
    task automatic set_fault(input logic [31:0] f);
        flt      = f;
        exp_tt   = GOLD ^ f;
        for (int g = 0; g < 8; g++) begin
            exp_fm[g] = (f[4*g +: 4] != 4'h0);
        end
        exp_pass = (f == 32'h0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check instance i at position m (1-based) within its sweep; m > D means idle afterwards
    task automatic check_cycle(input int i, input int m);
        int s;
        int d;
        int drv;
        s   = s_of(i);
        d   = 4 * (s + 1) + 2;
        drv = (m <= 4 * (s + 1)) ? (m - 1) / (s + 1) : 0;
        checkOutput($sformatf("dut%0d.busy@%0d", i, m), 32'(busy_d[i]), 32'(m <= d));
        checkOutput($sformatf("dut%0d.done@%0d", i, m), 32'(done_d[i]), 32'(m == d));
        checkOutput($sformatf("dut%0d.drive@%0d", i, m), {30'b0, a_d[i], b_d[i]}, 32'(drv));
        if (m < d) begin
            checkOutput($sformatf("dut%0d.fail_mask@%0d", i, m), 32'(fm_d[i]), 32'h0);
            checkOutput($sformatf("dut%0d.pass@%0d", i, m), 32'(pass_d[i]), 32'h0);
        end else begin
            checkOutput($sformatf("dut%0d.tt_out@%0d", i, m), tt_d[i], exp_tt);
            checkOutput($sformatf("dut%0d.fail_mask@%0d", i, m), 32'(fm_d[i]), 32'(exp_fm));
            checkOutput($sformatf("dut%0d.pass@%0d", i, m), 32'(pass_d[i]), 32'(exp_pass));
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("%s.dut%0d.busy", tag, i), 32'(busy_d[i]), 32'h0);
            checkOutput($sformatf("%s.dut%0d.done", tag, i), 32'(done_d[i]), 32'h0);
            checkOutput($sformatf("%s.dut%0d.drive", tag, i), {30'b0, a_d[i], b_d[i]}, 32'h0);
            checkOutput($sformatf("%s.dut%0d.tt_out", tag, i), tt_d[i], 32'h0);
            checkOutput($sformatf("%s.dut%0d.fail_mask", tag, i), 32'(fm_d[i]), 32'h0);
            checkOutput($sformatf("%s.dut%0d.pass", tag, i), 32'(pass_d[i]), 32'h0);
        end
    endtask

    // One start pulse, then every instance is checked each cycle until all are idle again
    task automatic applyStimulus(input logic [31:0] f);
        set_fault(f);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 28; n++) begin
            for (int i = 0; i < NI; i++) begin
                check_cycle(i, n);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        set_fault(32'h0);

        // Reset held two cycles with start high: nothing may begin
        @(negedge clk);
        check_reset_state("reset1");
        @(negedge clk);
        check_reset_state("reset2");
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_reset_state("post_reset");

        // Healthy block, xor stuck at 0, and/nand swapped
        applyStimulus(32'h0000_0000);
        applyStimulus(32'h0600_0000);
        applyStimulus(32'h00F0_000F);

        // Randomized fault patterns, some sweeps fault-free
        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(32'h0);
            end else begin
                applyStimulus($urandom & $urandom);
            end
        end

        // start held high: back-to-back sweeps, each restarting in the IDLE cycle after DONE
        set_fault($urandom & 32'h0F0F_F0F0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int n = 1; n <= 60; n++) begin
            for (int i = 0; i < NI; i++) begin
                check_cycle(i, (n - 1) % (4 * (s_of(i) + 1) + 3) + 1);
            end
            @(negedge clk);
        end
        start = 1'b0;
        repeat (30) @(negedge clk);

        // Reset in dut0's SAMPLE cycle for idx 2 discards the partial sweep
        set_fault($urandom);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            for (int i = 0; i < NI; i++) begin
                check_cycle(i, n);
            end
            @(negedge clk);
            if (n == 8) begin
                rst = 1'b1;
            end
        end
        check_reset_state("mid_reset");
        rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            checkOutput($sformatf("no_done_after_reset@%0d", n), 32'(done_d[0] | done_d[1] | done_d[2]), 32'h0);
        end

        // A fresh sweep after the aborted one gives a complete result
        applyStimulus(32'h0);
        applyStimulus($urandom);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
